// File: rtl/spdif_rx.sv
// spdif_rx: S/PDIF receiver and BMC decoder.
// The line is oversampled on clk. The time between transitions is classified as
// 1, 2 or 3 half-cells. Preambles and 28 data cells are decoded from those pulses.
module spdif_rx #(
   parameter int UNIT_CLKS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spdif_in,
   output logic [15:0] left_out,
   output logic [15:0] right_out,
   output logic        left_valid,
   output logic        right_valid,
   output logic        block_start,
   output logic        parity_err,
   output logic        code_err,
   output logic        locked
);
   localparam int CNT_W = $clog2(4 * UNIT_CLKS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(4 * UNIT_CLKS);
   // Thresholds are compared against 2*L so that no division is needed.
   localparam logic [CNT_W:0] TH_3U = (CNT_W + 1)'(3 * UNIT_CLKS);
   localparam logic [CNT_W:0] TH_5U = (CNT_W + 1)'(5 * UNIT_CLKS);
   localparam logic [CNT_W:0] TH_7U = (CNT_W + 1)'(7 * UNIT_CLKS);

   typedef enum logic [1:0] {PL_1, PL_2, PL_3, PL_X} pulse_t;
   typedef enum logic [1:0] {HUNT, PRE, DATA} state_t;

   logic             sync1_q, sync2_q, prev_q;
   logic             edge_s;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   two_len;
   pulse_t           pulse_cls, pulse_q;
   logic             pulse_vld_q, tmo_q;

   state_t           state_q;
   logic [1:0]       pre_idx_q;
   pulse_t           pre1_q, pre2_q;
   logic [5:0]       cell_q;
   logic             half_q;
   logic [27:0]      sr_q;
   logic             ch_q, blk_q, done_q, err_q;

   logic [15:0]      left_q, right_q;
   logic             left_vld_q, right_vld_q, blk_out_q, par_err_q, code_err_q, locked_q;
   logic [1:0]       run_q;
   logic             last_ch_q;

   assign edge_s  = sync2_q ^ prev_q;
   assign two_len = {cnt_q, 1'b0};

   // Two-flop synchronizer followed by a previous-value flop for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= spdif_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Pulse counter: restarts at 1 on an edge, saturates at 4 half-cells.
   always_comb begin
      cnt_d = cnt_q;
      if (edge_s)
         cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX)
         cnt_d = cnt_q + 1'b1;
   end

   // Classify the length of the pulse that the current edge terminates.
   always_comb begin
      if (two_len < TH_3U)
         pulse_cls = PL_1;
      else if (two_len < TH_5U)
         pulse_cls = PL_2;
      else if (two_len < TH_7U)
         pulse_cls = PL_3;
      else
         pulse_cls = PL_X;
   end

   // Register the counter, the classified pulse and the one-shot timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         pulse_q     <= PL_1;
         pulse_vld_q <= 1'b0;
         tmo_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         pulse_q     <= pulse_cls;
         pulse_vld_q <= edge_s;
         tmo_q       <= !edge_s && (cnt_q == CNT_MAX - 1'b1);
      end
   end

   // Decoder FSM: it consumes one classified pulse (or a timeout) per cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= HUNT;
         pre_idx_q <= 2'd0;
         pre1_q    <= PL_1;
         pre2_q    <= PL_1;
         cell_q    <= 6'd0;
         half_q    <= 1'b0;
         sr_q      <= '0;
         ch_q      <= 1'b0;
         blk_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (tmo_q && state_q != HUNT) begin
            err_q   <= 1'b1;
            state_q <= HUNT;
         end else if (pulse_vld_q) begin
            case (state_q)
               HUNT: begin
                  if (pulse_q == PL_3) begin
                     state_q   <= PRE;
                     pre_idx_q <= 2'd1;
                  end
               end
               PRE: begin
                  if (pre_idx_q == 2'd1) begin
                     pre1_q    <= pulse_q;
                     pre_idx_q <= 2'd2;
                  end else if (pre_idx_q == 2'd2) begin
                     pre2_q    <= pulse_q;
                     pre_idx_q <= 2'd3;
                  end else begin
                     state_q <= DATA;
                     cell_q  <= 6'd4;
                     half_q  <= 1'b0;
                     if (pre1_q == PL_1 && pre2_q == PL_1 && pulse_q == PL_3) begin
                        ch_q  <= 1'b0;
                        blk_q <= 1'b1;
                     end else if (pre1_q == PL_3 && pre2_q == PL_1 && pulse_q == PL_1) begin
                        ch_q  <= 1'b0;
                        blk_q <= 1'b0;
                     end else if (pre1_q == PL_2 && pre2_q == PL_1 && pulse_q == PL_2) begin
                        ch_q  <= 1'b1;
                        blk_q <= 1'b0;
                     end else begin
                        err_q   <= 1'b1;
                        state_q <= HUNT;
                     end
                  end
               end
               DATA: begin
                  if (cell_q == 6'd32) begin
                     // All cells are in; only the next preamble's long pulse is legal.
                     if (pulse_q == PL_3) begin
                        state_q   <= PRE;
                        pre_idx_q <= 2'd1;
                     end else begin
                        err_q   <= 1'b1;
                        state_q <= HUNT;
                     end
                  end else begin
                     case (pulse_q)
                        PL_1: begin
                           if (half_q) begin
                              sr_q   <= {1'b1, sr_q[27:1]};
                              cell_q <= cell_q + 1'b1;
                              half_q <= 1'b0;
                              done_q <= (cell_q == 6'd31);
                           end else begin
                              half_q <= 1'b1;
                           end
                        end
                        PL_2: begin
                           if (half_q) begin
                              err_q   <= 1'b1;
                              state_q <= HUNT;
                           end else begin
                              sr_q   <= {1'b0, sr_q[27:1]};
                              cell_q <= cell_q + 1'b1;
                              done_q <= (cell_q == 6'd31);
                           end
                        end
                        default: begin
                           err_q   <= 1'b1;
                           state_q <= HUNT;
                        end
                     endcase
                  end
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end

   // Commit decoded subframes and errors to the registered outputs and track lock.
   always_ff @(posedge clk) begin
      if (reset) begin
         left_q      <= '0;
         right_q     <= '0;
         left_vld_q  <= 1'b0;
         right_vld_q <= 1'b0;
         blk_out_q   <= 1'b0;
         par_err_q   <= 1'b0;
         code_err_q  <= 1'b0;
         locked_q    <= 1'b0;
         run_q       <= 2'd0;
         last_ch_q   <= 1'b0;
      end else begin
         left_vld_q  <= 1'b0;
         right_vld_q <= 1'b0;
         blk_out_q   <= 1'b0;
         par_err_q   <= 1'b0;
         code_err_q  <= 1'b0;
         if (err_q) begin
            code_err_q <= 1'b1;
            locked_q   <= 1'b0;
            run_q      <= 2'd0;
         end else if (done_q) begin
            if (ch_q) begin
               right_q     <= sr_q[23:8];
               right_vld_q <= 1'b1;
            end else begin
               left_q     <= sr_q[23:8];
               left_vld_q <= 1'b1;
               blk_out_q  <= blk_q;
            end
            par_err_q <= ^sr_q;
            last_ch_q <= ch_q;
            // A run of alternating channels locks on its second subframe.
            if (run_q != 2'd0 && ch_q != last_ch_q) begin
               run_q    <= 2'd2;
               locked_q <= 1'b1;
            end else begin
               run_q    <= 2'd1;
               locked_q <= 1'b0;
            end
         end
      end
   end

   assign left_out    = left_q;
   assign right_out   = right_q;
   assign left_valid  = left_vld_q;
   assign right_valid = right_vld_q;
   assign block_start = blk_out_q;
   assign parity_err  = par_err_q;
   assign code_err    = code_err_q;
   assign locked      = locked_q;

endmodule

// File: tb/tb_spdif_rx.sv
// tb_spdif_rx: drives BMC-encoded subframes into spdif_rx. Each expected output
// event (sample commit or code error) is queued when issued. A monitor compares the
// queued events against the DUT strobes.
module tb_spdif_rx;
   localparam int U = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        spdif_in;
   logic [15:0] left_out, right_out;
   logic        left_valid, right_valid, block_start, parity_err, code_err, locked;

   always #5 clk = ~clk;

   spdif_rx #(.UNIT_CLKS(U)) dut (
      .clk(clk),
      .reset(reset),
      .spdif_in(spdif_in),
      .left_out(left_out),
      .right_out(right_out),
      .left_valid(left_valid),
      .right_valid(right_valid),
      .block_start(block_start),
      .parity_err(parity_err),
      .code_err(code_err),
      .locked(locked)
   );

   // kind: 0 = left commit, 1 = right commit, 2 = code error
   typedef struct packed {
      logic [1:0]  kind;
      logic [15:0] sample;
      logic        bs;
      logic        pe;
      logic        lk;
   } ev_t;

   ev_t exp_q[$];
   int  tests = 0;
   int  fails = 0;
   int  ev_num = 0;
   bit  jit = 1'b0;
   ev_t mon_got, mon_exp;
   int  mon_n;

   // Monitor: every strobe cycle must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && (left_valid || right_valid || code_err)) begin
         mon_got.kind   = code_err ? 2'd2 : (right_valid ? 2'd1 : 2'd0);
         mon_got.sample = code_err ? 16'h0000 : (right_valid ? right_out : left_out);
         mon_got.bs     = block_start;
         mon_got.pe     = parity_err;
         mon_got.lk     = locked;
         mon_n = int'(left_valid) + int'(right_valid) + int'(code_err);
         tests++;
         ev_num++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event%0d got kind=%0d smp=%h bs=%b pe=%b lk=%b, expected no event",
                     ev_num, mon_got.kind, mon_got.sample, mon_got.bs, mon_got.pe, mon_got.lk);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp || mon_n != 1) begin
               fails++;
               $display("FAIL event%0d got kind=%0d smp=%h bs=%b pe=%b lk=%b strobes=%0d, expected kind=%0d smp=%h bs=%b pe=%b lk=%b strobes=1",
                        ev_num, mon_got.kind, mon_got.sample, mon_got.bs, mon_got.pe, mon_got.lk, mon_n,
                        mon_exp.kind, mon_exp.sample, mon_exp.bs, mon_exp.pe, mon_exp.lk);
            end else begin
               $display("[TB] event%0d kind=%0d smp=%h bs=%b pe=%b lk=%b ok",
                        ev_num, mon_got.kind, mon_got.sample, mon_got.bs, mon_got.pe, mon_got.lk);
            end
         end
      end
   end

   // Toggle the line and hold it for n clocks.
   task automatic pulse(input int n);
      spdif_in = ~spdif_in;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Length in clocks of a k-half-cell pulse, optionally jittered (jitter is set up for U=4).
   function automatic int hlen(input int k);
      if (jit) begin
         if (k == 1) return int'($urandom_range(3, 5));
         if (k == 2) return int'($urandom_range(7, 9));
         return int'($urandom_range(11, 13));
      end
      return k * U;
   endfunction

   task automatic push_err();
      ev_t e;
      e = '{kind: 2'd2, sample: 16'h0000, bs: 1'b0, pe: 1'b0, lk: 1'b0};
      exp_q.push_back(e);
   endtask

   // pre: 0=B 1=M 2=W. mode: 0 normal, 1 P1,P2 at cell 15, 2 line stuck at cell 20.
   task automatic send_sf(input int pre, input logic [15:0] smp, input bit flip_p,
                          input int mode, input bit exp_lk);
      logic [27:0] c;
      ev_t e;
      c[7:0]   = 8'h5A;
      c[23:8]  = smp;
      c[26:24] = 3'b100;
      c[27]    = (^c[26:0]) ^ flip_p;
      case (pre)
         0:       begin pulse(hlen(3)); pulse(hlen(1)); pulse(hlen(1)); pulse(hlen(3)); end
         1:       begin pulse(hlen(3)); pulse(hlen(3)); pulse(hlen(1)); pulse(hlen(1)); end
         default: begin pulse(hlen(3)); pulse(hlen(2)); pulse(hlen(1)); pulse(hlen(2)); end
      endcase
      for (int i = 0; i < 28; i++) begin
         if (mode == 1 && i == 11) begin
            pulse(hlen(1));
            pulse(hlen(2));
            spdif_in = ~spdif_in;
            push_err();
            return;
         end
         if (mode == 2 && i == 16) begin
            spdif_in = 1'b1;
            push_err();
            idle(20 * U);
            return;
         end
         if (c[i]) begin
            pulse(hlen(1));
            pulse(hlen(1));
         end else begin
            pulse(hlen(2));
         end
      end
      e = '{kind: (pre == 2) ? 2'd1 : 2'd0, sample: smp, bs: (pre == 0), pe: flip_p, lk: exp_lk};
      exp_q.push_back(e);
   endtask

   // Close the last cell, then let the line go quiet: expect a timeout error.
   task automatic end_seg();
      spdif_in = ~spdif_in;
      push_err();
      idle(30 * U);
   endtask

   task automatic check_zero(input string name);
      logic [37:0] v;
      v = {left_out, right_out, left_valid, right_valid, block_start, parity_err, code_err, locked};
      tests++;
      if (v !== 38'd0) begin
         fails++;
         $display("FAIL %s got outputs=%h, expected all zero", name, v);
      end else begin
         $display("[TB] %s outputs all zero ok", name);
      end
   endtask

   initial begin
      reset    = 1'b1;
      spdif_in = 1'b0;
      idle(5);
      check_zero("reset_state");
      reset = 1'b0;
      idle(10 * U);

      // Clean stream, lock on the second subframe.
      send_sf(0, 16'h8001, 1'b0, 0, 1'b0);
      send_sf(2, 16'h0000, 1'b0, 0, 1'b1);
      send_sf(1, 16'h1234, 1'b0, 0, 1'b1);
      send_sf(2, 16'hABCD, 1'b0, 0, 1'b1);
      end_seg();

      // Flipped parity cell: still committed, lock held.
      send_sf(1, 16'hAAAA, 1'b0, 0, 1'b0);
      send_sf(2, 16'h5555, 1'b0, 0, 1'b1);
      send_sf(1, 16'h0F0F, 1'b1, 0, 1'b1);
      send_sf(2, 16'h1357, 1'b0, 0, 1'b1);
      end_seg();

      // BMC violation at cell 15, then relock.
      send_sf(1, 16'h1111, 1'b0, 0, 1'b0);
      send_sf(2, 16'h2222, 1'b0, 0, 1'b1);
      send_sf(1, 16'h9999, 1'b0, 1, 1'b0);
      idle(30 * U);
      send_sf(2, 16'h3333, 1'b0, 0, 1'b0);
      send_sf(1, 16'h4444, 1'b0, 0, 1'b1);
      end_seg();

      // Line stuck mid-DATA.
      send_sf(1, 16'h0123, 1'b0, 0, 1'b0);
      send_sf(2, 16'h0000, 1'b0, 2, 1'b0);
      idle(10 * U);

      // Two consecutive left subframes drop lock.
      send_sf(2, 16'h0001, 1'b0, 0, 1'b0);
      send_sf(1, 16'h0002, 1'b0, 0, 1'b1);
      send_sf(1, 16'h0003, 1'b0, 0, 1'b0);
      end_seg();

      // Jittered pulse lengths.
      jit = 1'b1;
      send_sf(0, 16'h600D, 1'b0, 0, 1'b0);
      send_sf(2, 16'hBEEF, 1'b0, 0, 1'b1);
      send_sf(1, 16'hCAFE, 1'b0, 0, 1'b1);
      send_sf(2, 16'hF00D, 1'b0, 0, 1'b1);
      send_sf(1, 16'h7E57, 1'b0, 0, 1'b1);
      send_sf(2, 16'h0BAD, 1'b0, 0, 1'b1);
      end_seg();
      jit = 1'b0;

      // Reset in the middle of a preamble.
      pulse(3 * U);
      pulse(U);
      reset = 1'b1;
      idle(1);
      check_zero("reset_mid_pre");
      idle(2);
      reset = 1'b0;
      idle(30 * U);
      send_sf(2, 16'h7777, 1'b0, 0, 1'b0);
      send_sf(1, 16'h8888, 1'b0, 0, 1'b1);
      end_seg();

      for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain got %0d pending events, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
